// File: rtl/alu_sequencer.sv
// Bus-side sequencer for the ALU: gathers two operands off the shared bus, runs one
// add/subtract, then captures the ALU result and flags back off the same bus.
module alu_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_subtract,
    input  logic [7:0] i_bus,
    input  logic       i_bus_valid,
    input  logic       i_flag_c,
    input  logic       i_flag_z,
    output logic [7:0] o_data_a,
    output logic [7:0] o_data_b,
    output logic       o_alu_subtract,
    output logic       o_alu_read_n,
    output logic       o_alu_read_flags_n,
    output logic       o_bus_busy,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_error,
    output logic [7:0] o_result,
    output logic       o_flag_c,
    output logic       o_flag_z
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          op, op_nxt;
    logic          cap_a, cap_b, cap_res;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        cap_res   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    op_nxt    = i_subtract;
                    cnt_nxt   = '0;
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: begin
                if (i_bus_valid) begin
                    cap_a     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = LOAD_B;
                end else if (cnt == TMAX) begin
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOAD_B: begin
                if (i_bus_valid) begin
                    cap_b     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = EXEC;
                end else if (cnt == TMAX) begin
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // ALU drives the bus during this cycle; sample it on the closing edge
            EXEC: begin
                cap_res   = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
        end
    end

    // Control outputs are registered off the next state so they line up with the state itself
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ready            <= 1'b1;
            o_alu_read_n       <= 1'b1;
            o_alu_read_flags_n <= 1'b1;
            o_bus_busy         <= 1'b0;
            o_alu_subtract     <= 1'b0;
            o_done             <= 1'b0;
            o_error            <= 1'b0;
        end else begin
            o_ready            <= (state_nxt == IDLE);
            o_alu_read_n       <= (state_nxt != EXEC);
            o_alu_read_flags_n <= (state_nxt != EXEC);
            o_bus_busy         <= (state_nxt == EXEC);
            o_alu_subtract     <= (state_nxt == EXEC) ? op_nxt : 1'b0;
            o_done             <= (state_nxt == DONE);
            o_error            <= (state_nxt == ERR);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data_a <= 8'h00;
            o_data_b <= 8'h00;
            o_result <= 8'h00;
            o_flag_c <= 1'b0;
            o_flag_z <= 1'b0;
        end else begin
            if (cap_a) o_data_a <= i_bus;
            if (cap_b) o_data_b <= i_bus;
            if (cap_res) begin
                o_result <= i_bus;
                o_flag_c <= i_flag_c;
                o_flag_z <= i_flag_z;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed operations push expected results,
// a negedge monitor pops and compares on every o_done/o_error pulse.
module tb_alu_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_subtract = 1'b0;
    logic [7:0] i_bus;
    logic       i_bus_valid = 1'b0;
    logic       i_flag_c, i_flag_z;
    logic [7:0] o_data_a, o_data_b, o_result;
    logic       o_alu_subtract, o_alu_read_n, o_alu_read_flags_n, o_bus_busy;
    logic       o_ready, o_done, o_error, o_flag_c, o_flag_z;

    logic [7:0] src_bus = 8'hAA;
    logic [8:0] alu9;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic       err;
        logic [7:0] res;
        logic       c;
        logic       z;
        int         cyc;
    } exp_t;
    exp_t q[$];

    alu_sequencer #(.TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_subtract(i_subtract),
        .i_bus(i_bus), .i_bus_valid(i_bus_valid), .i_flag_c(i_flag_c), .i_flag_z(i_flag_z),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_alu_subtract(o_alu_subtract),
        .o_alu_read_n(o_alu_read_n), .o_alu_read_flags_n(o_alu_read_flags_n),
        .o_bus_busy(o_bus_busy), .o_ready(o_ready), .o_done(o_done), .o_error(o_error),
        .o_result(o_result), .o_flag_c(o_flag_c), .o_flag_z(o_flag_z)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ALU model: drives the shared bus and flags only while enabled
    assign alu9     = o_alu_subtract ? ({1'b0, o_data_a} - {1'b0, o_data_b})
                                     : ({1'b0, o_data_a} + {1'b0, o_data_b});
    assign i_bus    = o_alu_read_n ? src_bus : alu9[7:0];
    assign i_flag_c = o_alu_read_flags_n ? 1'b0 : alu9[8];
    assign i_flag_z = o_alu_read_flags_n ? 1'b0 : (alu9 == 9'd0);

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n && (o_done || o_error)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {o_done, o_error}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("kind_error", o_error, e.err);
                chk("kind_done", o_done, !e.err);
                chk("result", o_result, e.res);
                chk("flag_c", o_flag_c, e.c);
                chk("flag_z", o_flag_z, e.z);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                          input int dly_a, input logic rep_start, input logic do_push,
                          input logic [7:0] er, input logic ec, input logic ez);
        int s;
        @(negedge i_clk);
        i_start = 1'b1; i_subtract = sub;
        @(posedge i_clk); #1;
        s = cyc;
        i_start = 1'b0; i_subtract = ~sub;
        if (do_push) q.push_back('{1'b0, er, ec, ez, s + 3 + dly_a});
        repeat (dly_a) begin @(posedge i_clk); #1; end
        src_bus = a; i_bus_valid = 1'b1;
        @(posedge i_clk); #1;
        src_bus = b; i_start = rep_start;
        @(posedge i_clk); #1;
        i_bus_valid = 1'b0; i_start = 1'b0; src_bus = 8'h55;
        chk("exec_busy", o_bus_busy, 1);
        chk("exec_read_n", o_alu_read_n, 0);
    endtask

    task automatic timeout_op(input logic give_a, input logic [7:0] a,
                              input logic [7:0] er, input logic ec, input logic ez);
        int s;
        @(negedge i_clk);
        i_start = 1'b1; i_subtract = 1'b0;
        @(posedge i_clk); #1;
        s = cyc;
        i_start = 1'b0;
        q.push_back('{1'b1, er, ec, ez, s + 16 + (give_a ? 1 : 0)});
        if (give_a) begin
            src_bus = a; i_bus_valid = 1'b1;
            @(posedge i_clk); #1;
            i_bus_valid = 1'b0; src_bus = 8'hAA;
        end
        repeat (20) @(posedge i_clk);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_read_n", o_alu_read_n, 1);
        chk("rst_read_flags_n", o_alu_read_flags_n, 1);
        chk("rst_busy", o_bus_busy, 0);
        chk("rst_result", o_result, 0);
        chk("rst_done_err", {o_done, o_error}, 0);
        chk("rst_data", {o_data_a, o_data_b}, 0);
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);

        run_op(1'b0, 8'h05, 8'h03, 0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        run_op(1'b1, 8'h03, 8'h03, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        repeat (2) @(posedge i_clk);
        run_op(1'b0, 8'hC8, 8'h64, 0, 1'b0, 1'b1, 8'h2C, 1'b1, 1'b0);
        repeat (2) @(posedge i_clk);
        run_op(1'b1, 8'h02, 8'h05, 0, 1'b0, 1'b1, 8'hFD, 1'b1, 1'b0);
        repeat (2) @(posedge i_clk);
        timeout_op(1'b0, 8'h00, 8'hFD, 1'b1, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge i_clk);
        timeout_op(1'b1, 8'h11, 8'h00, 1'b1, 1'b0);
        run_op(1'b0, 8'h10, 8'h20, 5, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        run_op(1'b1, 8'h40, 8'h01, 0, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b0);
        repeat (4) @(posedge i_clk);
        chk("overlap_single_done", q.size(), 0);

        // reset in the middle of EXEC: enables must drop at once, no pulse afterwards
        run_op(1'b0, 8'h77, 8'h11, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1 i_reset_n = 1'b0;
        #1;
        chk("midrst_read_n", o_alu_read_n, 1);
        chk("midrst_read_flags_n", o_alu_read_flags_n, 1);
        chk("midrst_busy", o_bus_busy, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_result", o_result, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (4) @(posedge i_clk);

        run_op(1'b0, 8'h01, 8'h02, 0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        repeat (4) @(posedge i_clk);
        chk("queue_drained", q.size(), 0);
        chk("final_ready", o_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
